// File: rtl/stack_cmd_driver.sv
// Request/response sequencer in front of the 5-entry circular stack.
// Commands are launched on the falling edge so the stack samples each one at exactly one rising edge.
module stack_cmd_driver #(
  parameter int DEPTH = 5,
  parameter int DW    = 4,
  parameter int IW    = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_data,
  input  logic [IW-1:0] req_index,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [2:0]    count,
  output logic          STK_RESET,
  output logic [1:0]    STK_COMMAND,
  output logic [IW-1:0] STK_INDEX,
  inout  wire  [DW-1:0] IO_DATA
);

  typedef enum logic [1:0] {OP_CLEAR, OP_PUSH, OP_POP, OP_GET} op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_e;

  typedef struct packed {
    logic [1:0]    cmd;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          clr;
  } launch_t;

  state_e        state, state_nx;
  op_e           op_q;
  launch_t       lp, ln;
  logic          accept, illegal;
  logic [DW-1:0] rd_latch;

  always_comb begin
    illegal = 1'b0;
    case (op_e'(req_op))
      OP_PUSH: illegal = (32'(count) >= DEPTH);
      OP_POP:  illegal = (count == 3'd0);
      OP_GET:  illegal = (32'(req_index) >= 32'(count));
      default: illegal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !RESET;
        if (req_valid && !RESET) begin
          accept   = 1'b1;
          state_nx = illegal ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: state_nx = S_CAPT;
      S_CAPT: state_nx = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lp       <= '0;
      op_q     <= OP_CLEAR;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      count    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q <= op_e'(req_op);
          if (illegal) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else begin
            rsp_err <= 1'b0;
            // CLEAR reaches the stack as a NOP plus the reset pulse
            lp.cmd  <= (op_e'(req_op) == OP_CLEAR) ? 2'b00 : req_op;
            lp.idx  <= req_index;
            lp.data <= req_data;
            lp.clr  <= (op_e'(req_op) == OP_CLEAR);
          end
        end
        S_EXEC: begin
          lp.cmd <= 2'b00;
          lp.clr <= 1'b0;
        end
        S_CAPT: begin
          case (op_q)
            OP_PUSH: begin
              rsp_data <= lp.data;
              count    <= count + 3'd1;
            end
            OP_POP: begin
              rsp_data <= rd_latch;
              count    <= count - 3'd1;
            end
            OP_GET:  rsp_data <= rd_latch;
            default: begin
              rsp_data <= '0;
              count    <= 3'd0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge CLK) begin
    if (RESET) ln <= '0;
    else       ln <= lp;
  end

  assign STK_COMMAND = ln.cmd;
  assign STK_INDEX   = ln.idx;
  assign STK_RESET   = RESET | ln.clr;
  assign IO_DATA     = (ln.cmd == 2'b01) ? ln.data : 'z;

  // Open only in the high phase that follows the stack sampling a read command
  always_latch begin
    if (CLK && ln.cmd[1]) rd_latch <= IO_DATA;
  end

endmodule

// File: tb/tb_stack_cmd_driver.sv
// Directed bench for stack_cmd_driver with a behavioural 5-entry stack on the shared bus.
module tb_stack_cmd_driver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_data = 4'd0;
  logic [2:0] req_index = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [2:0] count;
  logic       STK_RESET;
  logic [1:0] STK_COMMAND;
  logic [2:0] STK_INDEX;
  wire  [3:0] IO_DATA;

  stack_cmd_driver #(.DEPTH(5), .DW(4), .IW(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .count(count),
    .STK_RESET(STK_RESET), .STK_COMMAND(STK_COMMAND), .STK_INDEX(STK_INDEX),
    .IO_DATA(IO_DATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // behavioural stack: samples command on posedge, drives bus while a read command is present
  logic [3:0] st [0:4];
  int         sc = 0;
  int         stk_bad = 0;
  logic [3:0] stk_o = 4'd0;
  int         cmd_edges = 0;
  int         rst_edges = 0;

  always @(posedge CLK) begin
    if (STK_COMMAND != 2'b00) cmd_edges <= cmd_edges + 1;
    if (STK_RESET) rst_edges <= rst_edges + 1;
    if (STK_RESET) sc <= 0;
    else case (STK_COMMAND)
      2'b01: if (sc < 5) begin st[sc] <= IO_DATA; sc <= sc + 1; end
             else stk_bad <= stk_bad + 1;
      2'b10: if (sc > 0) begin stk_o <= st[sc-1]; sc <= sc - 1; end
             else stk_bad <= stk_bad + 1;
      2'b11: if (int'(STK_INDEX) < sc) stk_o <= st[sc-1-int'(STK_INDEX)];
             else stk_bad <= stk_bad + 1;
      default: ;
    endcase
  end

  assign IO_DATA = STK_COMMAND[1] ? stk_o : 4'bzzzz;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] idx;
    int         exp_data;
    int         exp_err;
    int         exp_count;
    int         exp_lat;
    int         exp_cmd;
    int         exp_clr;
  } vec_t;

  function automatic vec_t mk(input int op, input int d, input int ix, input int ed,
                              input int ee, input int ec, input int el, input int ecmd,
                              input int eclr);
    vec_t v;
    v.op = 2'(op); v.data = 4'(d); v.idx = 3'(ix);
    v.exp_data = ed; v.exp_err = ee; v.exp_count = ec;
    v.exp_lat = el; v.exp_cmd = ecmd; v.exp_clr = eclr;
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin @(posedge CLK); #1; w++; end
    check({tag, "_req_ready"}, int'(req_ready), 1);
  endtask

  task automatic do_req(input string tag, input vec_t v);
    int lat, c0, r0;
    wait_ready(tag);
    c0 = cmd_edges; r0 = rst_edges;
    req_valid = 1'b1; req_op = v.op; req_data = v.data; req_index = v.idx;
    @(posedge CLK); #1;
    // scramble request fields: only the accepted values may matter
    req_valid = 1'b0; req_op = ~v.op; req_data = ~v.data; req_index = ~v.idx;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (!rsp_valid && lat < 20);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_rsp_data"}, int'(rsp_data), v.exp_data);
    check({tag, "_rsp_err"}, int'(rsp_err), v.exp_err);
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_drop"}, int'(rsp_valid), 0);
    check({tag, "_count"}, int'(count), v.exp_count);
    check({tag, "_cmd_edges"}, cmd_edges - c0, v.exp_cmd);
    check({tag, "_clr_edges"}, rst_edges - r0, v.exp_clr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   lat;

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_err", int'(rsp_err), 0);
    check("rst_count", int'(count), 0);
    check("rst_stk_command", int'(STK_COMMAND), 0);
    check("rst_stk_index", int'(STK_INDEX), 0);
    check("rst_stk_reset", int'(STK_RESET), 1);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_stk_reset", int'(STK_RESET), 0);

    // op: 0 CLEAR, 1 PUSH, 2 POP, 3 GET
    vecs.push_back(mk(1, 3, 0, 3, 0, 1, 2, 1, 0));
    vecs.push_back(mk(1, 7, 0, 7, 0, 2, 2, 1, 0));
    vecs.push_back(mk(1, 9, 0, 9, 0, 3, 2, 1, 0));
    vecs.push_back(mk(3, 0, 0, 9, 0, 3, 2, 1, 0));
    vecs.push_back(mk(3, 0, 2, 3, 0, 3, 2, 1, 0));
    vecs.push_back(mk(2, 0, 0, 9, 0, 2, 2, 1, 0));
    vecs.push_back(mk(3, 0, 2, 0, 1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(2, 5, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 1, 0, 1, 0, 0));
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(1, k, 0, k, 0, k, 2, 1, 0));
    vecs.push_back(mk(1, 6, 0, 0, 1, 5, 1, 0, 0));
    vecs.push_back(mk(3, 0, 4, 1, 0, 5, 2, 1, 0));
    vecs.push_back(mk(3, 0, 5, 0, 1, 5, 1, 0, 0));
    vecs.push_back(mk(3, 0, 7, 0, 1, 5, 1, 0, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(2, 0, 0, 5 - k, 0, 4 - k, 2, 1, 0));

    for (int i = 0; i < vecs.size(); i++) do_req($sformatf("v%0d", i), vecs[i]);

    // response backpressure on a POP
    do_req("bp_push", mk(1, 10, 0, 10, 0, 1, 2, 1, 0));
    wait_ready("bp_pop");
    req_valid = 1'b1; req_op = 2'b10;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(posedge CLK); #1; lat++; end while (!rsp_valid && lat < 20);
    check("bp_latency", lat, 2);
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      check($sformatf("bp_hold%0d_valid", c), int'(rsp_valid), 1);
      check($sformatf("bp_hold%0d_data", c), int'(rsp_data), 10);
      check($sformatf("bp_hold%0d_req_ready", c), int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    check("bp_valid_drop", int'(rsp_valid), 0);
    check("bp_count", int'(count), 0);
    check("bp_req_ready", int'(req_ready), 1);

    // reset while a PUSH is in EXEC
    do_req("ab_push", mk(1, 2, 0, 2, 0, 1, 2, 1, 0));
    wait_ready("ab_push8");
    req_valid = 1'b1; req_op = 2'b01; req_data = 4'd8;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("ab_rsp_valid", int'(rsp_valid), 0);
    check("ab_count", int'(count), 0);
    @(posedge CLK); #1;
    check("ab_rsp_valid_later", int'(rsp_valid), 0);
    do_req("ab_get0", mk(3, 0, 0, 0, 1, 0, 1, 0, 0));

    check("stack_model_illegal_cmds", stk_bad, 0);
    check("stack_model_occupancy", sc, int'(count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
